bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
Upstream feeder for the serial sequence-detector FSM. It accepts parallel words over a valid/ready handshake and frames each one. For each word it emits a one-cycle start pulse, which drives the detector's start input. It then shifts the word out one bit per clock on sout, which drives the detector's serial input a. A programmable idle gap separates consecutive frames.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
GAP, 1, number of idle cycles after the last data bit before the next word can be accepted; 0 is legal.
IDLE_BIT, 0, value driven on sout when no data bit is being sent.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
din  in  WIDTH  parallel word, sampled on the handshake edge.
din_valid  in  1  upstream has a word.
din_ready  out  1  block can accept a word this cycle.
sout  out  1  serial data bit (to detector a).
sstart  out  1  one-cycle frame-start pulse (to detector start).
slast  out  1  high during the cycle carrying the last data bit of a frame.
busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled only on the rising edge of clk.
- State machine states: IDLE, START, SHIFT, GAP.
- State, shift register and bit counter are registered. All outputs are decoded from registered state only; there is no combinational path from din or din_valid to any output.
- Reset values, in effect in the cycle after a reset edge:
  - state = IDLE, shift register = 0, counter = 0.
  - din_ready = 1, sout = IDLE_BIT, sstart = 0, slast = 0, busy = 0.
- IDLE:
  - din_ready = 1; sout = IDLE_BIT.
  - On an edge with din_valid = 1 and reset = 0: load din into the shift register, clear the counter, go to START.
- START (exactly 1 cycle):
  - sstart = 1; sout = IDLE_BIT; din_ready = 0.
  - Next state is SHIFT.
  - The detector is held in its initial state during this cycle and consumes the first data bit at the following edge.
- SHIFT (exactly WIDTH cycles):
  - sout = current bit: MSB of the shift register if MSB_FIRST = 1, else LSB.
  - The shift register shifts toward the output end every cycle; the counter increments.
  - slast = 1 when counter = WIDTH-1.
  - After the last bit, go to GAP if GAP > 0, else to IDLE.
- GAP (exactly GAP cycles):
  - sout = IDLE_BIT; counter reloaded and counts GAP cycles.
  - Then go to IDLE.
- Latency: acceptance on edge E0; sstart is high in cycle 1 after E0; data bits occupy cycles 2..WIDTH+1.
- Frame period is 2+WIDTH+GAP cycles: IDLE accept cycle + START + WIDTH data cycles + GAP.
- din_valid while din_ready = 0 is ignored; din may change freely and is not re-sampled.
- Counter width is $clog2(max(WIDTH,GAP)+1). No wrap occurs within a legal frame.
- Reset mid-frame, in any state:
  - The frame is dropped and the FSM returns to IDLE at that edge.
  - No slast or sstart is produced for the dropped frame.
  - din_valid is ignored on any edge where reset = 1.
- If reset and din_valid are high on the same edge, reset wins and no word is accepted.

Decomposition:
- Shared package serializer_pkg:
  - statetype enum {IDLE, START, SHIFT, GAP}, 2-bit logic encoding.
  - Localparam for the counter-width function.
- One natural sub-module, piso_shift: a parallel-in/serial-out register with load, shift enable and direction parameter. The FSM in bit_serializer owns the counter and outputs.

Test Plan:
1. Reset, then 5 idle cycles with din_valid = 0 -> din_ready = 1, sout = 0, sstart = 0, slast = 0, busy = 0 every cycle.
2. WIDTH = 8, MSB_FIRST = 1, GAP = 1; send 8'hB4 -> sstart = 1 in cycle 1 after acceptance; sout = 1,0,1,1,0,1,0,0 in cycles 2..9; slast only in cycle 9; GAP in cycle 10; din_ready back to 1 in cycle 11.
3. MSB_FIRST = 0; send 8'hB4 -> sout = 0,0,1,0,1,1,0,1 in cycles 2..9.
4. Back-to-back with din_valid held high: 8'hFF then 8'h01, with din changed while busy -> second acceptance exactly 11 cycles after the first; the second frame carries 8'h01 MSB-first (0,0,0,0,0,0,0,1); no spurious acceptance while busy.
5. GAP = 0; send 8'hA5 twice back-to-back -> period of 10 cycles; IDLE immediately follows the slast cycle; bits 1,0,1,0,0,1,0,1 in both frames.
6. Reset asserted for 1 cycle during the 4th data bit of 8'hB4 -> next cycle shows IDLE outputs with no slast; then 8'h3C is accepted and sent as 0,0,1,1,1,1,0,0 with correct sstart and slast.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the bit serializer.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } statetype;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Counter must hold both the bit index (0..WIDTH-1) and the gap index (0..GAP-1).
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in/serial-out register; the serial tap sits at the end the word drains toward.
module piso_shift #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sbit
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (reset)
      sreg <= '0;
    else if (load)
      sreg <= din;
    else if (shift_en) begin
      if (MSB_FIRST != 0)
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      else
        sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign sbit = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/bit_serializer.sv
// Frames parallel words for the serial sequence detector: start pulse, WIDTH data bits, idle gap.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter int   GAP       = 1,
  parameter logic IDLE_BIT  = 1'b0
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sstart,
  output logic             slast,
  output logic             busy
);
  import serializer_pkg::*;

  // The GAP parameter shadows the state name locally, so the state is package-qualified.
  localparam int            CW       = cnt_width(WIDTH, GAP);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'((GAP > 0) ? GAP - 1 : 0);

  statetype      state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          load, shift_en, ser_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid) begin
          load     = 1'b1;
          cnt_nx   = '0;
          state_nx = START;
        end
      end
      START: state_nx = SHIFT;
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == LAST_BIT) begin
          cnt_nx   = '0;
          state_nx = (GAP > 0) ? serializer_pkg::GAP : IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      serializer_pkg::GAP: begin
        if (cnt == LAST_GAP) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  piso_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .din      (din),
    .sbit     (ser_bit)
  );

  // Outputs depend only on registered state, never on din/din_valid.
  always_comb begin
    din_ready = (state == IDLE);
    sstart    = (state == START);
    slast     = (state == SHIFT) && (cnt == LAST_BIT);
    busy      = (state != IDLE);
    sout      = (state == SHIFT) ? ser_bit : IDLE_BIT;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Three serializer configurations driven in lockstep and checked against a frame-position model.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic [2:0]   rdy, so, st, sl, bz;

  int           n_cmp = 0;
  int           n_err = 0;
  bit           chk_en = 1'b0;

  int           msbf[3] = '{1, 0, 1};
  int           gaps[3] = '{1, 1, 0};
  int           phase[3] = '{0, 0, 0};
  logic [W-1:0] word[3];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .GAP(1), .IDLE_BIT(1'b0)) u_d0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
    .sout(so[0]), .sstart(st[0]), .slast(sl[0]), .busy(bz[0]));
  bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .GAP(1), .IDLE_BIT(1'b0)) u_d1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
    .sout(so[1]), .sstart(st[1]), .slast(sl[1]), .busy(bz[1]));
  bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .GAP(0), .IDLE_BIT(1'b0)) u_d2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy[2]),
    .sout(so[2]), .sstart(st[2]), .slast(sl[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, want %h", tag, $time, obs, exp);
    end
  endtask

  // Model: phase 0 = idle, 1 = start, 2..W+1 = data bits, then GAP idle cycles.
  function automatic logic [4:0] expect_out(input int d);
    int   p, idx;
    logic b;
    p   = phase[d];
    idx = p - 2;
    b   = 1'b0;
    if (idx >= 0 && idx < W)
      b = (msbf[d] != 0) ? word[d][W-1-idx] : word[d][idx];
    return {p == 0, b, p == 1, idx == W - 1, p != 0};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (reset)
        phase[d] = 0;
      else if (phase[d] == 0) begin
        if (din_valid) begin
          phase[d] = 1;
          word[d]  = din;
        end
      end else begin
        phase[d]++;
        if (phase[d] > W + 1 + gaps[d]) phase[d] = 0;
      end
    end
    #1;
    if (chk_en)
      for (int d = 0; d < 3; d++)
        chk($sformatf("d%0d_outs", d), 32'({rdy[d], so[d], st[d], sl[d], bz[d]}),
            32'(expect_out(d)));
  end

  task automatic send(input logic [W-1:0] w);
    din       = w;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d_reset", d), 32'({rdy[d], so[d], st[d], sl[d], bz[d]}), 32'(5'b10000));
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame.
    send(8'hB4);
    repeat (14) @(negedge clk);

    // Back-to-back with din changing while busy.
    din       = 8'hFF;
    din_valid = 1'b1;
    @(negedge clk);
    din = 8'h01;
    repeat (24) @(negedge clk);
    din_valid = 1'b0;
    repeat (14) @(negedge clk);

    // Continuous valid with a fixed word.
    din       = 8'hA5;
    din_valid = 1'b1;
    repeat (21) @(negedge clk);
    din_valid = 1'b0;
    repeat (14) @(negedge clk);

    // Reset during the 4th data bit, with valid high on the reset edge.
    send(8'hB4);
    repeat (4) @(negedge clk);
    reset     = 1'b1;
    din       = 8'h3C;
    din_valid = 1'b1;
    @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_midrst_busy", d), 32'(bz[d]), 32'(0));
      chk($sformatf("d%0d_midrst_slast", d), 32'(sl[d]), 32'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (14) @(negedge clk);

    // Random traffic with occasional resets.
    repeat (400) begin
      din       = W'($urandom);
      din_valid = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    reset     = 1'b0;
    din_valid = 1'b0;
    repeat (15) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
